// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared fetch-stage state encodings and pipeline control constants.
// Revision 1.0
`default_nettype none

package inst_fetch_pkg;

   localparam logic [2:0] IfIdle    = 3'd0;
   localparam logic [2:0] IfReq     = 3'd1;
   localparam logic [2:0] IfWait    = 3'd2;
   localparam logic [2:0] IfDiscard = 3'd3;
   localparam logic [2:0] IfDone    = 3'd4;

   localparam logic        Stop       = 1'b1;
   localparam logic        NoStop     = 1'b0;
   localparam logic        ChipEnable = 1'b1;
   localparam logic [31:0] ZeroWord   = 32'h00000000;

endpackage

`default_nettype wire

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch over an SRAM-like req/addr_ok/data_ok bus.
// Revision 1.0
`default_nettype none

module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_ADDR = ZeroWord,
   parameter logic [31:0] NOP_INST   = ZeroWord
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   input  logic        ce_i,
   input  logic        flush_i,
   input  logic [5:0]  stall_i,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic [31:0] inst_rdata,
   input  logic        inst_data_ok,
   output logic        stallreq_o,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_inst_o,
   output logic        if_valid_o
);

   logic [2:0]  state;
   logic [31:0] inst_buf;
   logic        drop;

   // Only the IF/ID hold bit matters to this stage.
   logic unused_stall;
   assign unused_stall = &{1'b0, stall_i[5:2], stall_i[0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IfIdle;
         inst_req  <= 1'b0;
         inst_addr <= RESET_ADDR;
         inst_buf  <= NOP_INST;
         drop      <= 1'b0;
      end else begin
         case (state)
            IfIdle: begin
               drop <= 1'b0;
               // pc_i is stale on a redirect cycle, so never issue then.
               if (ce_i == ChipEnable && !flush_i) begin
                  inst_req  <= 1'b1;
                  inst_addr <= pc_i;
                  state     <= IfReq;
               end
            end
            IfReq: begin
               if (inst_addr_ok) begin
                  inst_req <= 1'b0;
                  drop     <= 1'b0;
                  state    <= (drop || flush_i) ? IfDiscard : IfWait;
               end else if (flush_i) begin
                  drop <= 1'b1;
               end
            end
            IfWait: begin
               if (inst_data_ok) begin
                  if (flush_i) begin
                     state <= IfIdle;
                  end else begin
                     inst_buf <= inst_rdata;
                     state    <= IfDone;
                  end
               end else if (flush_i) begin
                  state <= IfDiscard;
               end
            end
            IfDiscard: begin
               if (inst_data_ok) begin
                  state <= IfIdle;
               end
            end
            IfDone: begin
               if (flush_i) begin
                  inst_buf <= NOP_INST;
                  state    <= IfIdle;
               end else if (!stall_i[1]) begin
                  state <= IfIdle;
               end
            end
            default: begin
               state    <= IfIdle;
               inst_req <= 1'b0;
            end
         endcase
      end
   end

   assign if_valid_o = (state == IfDone);
   assign if_inst_o  = if_valid_o ? inst_buf : NOP_INST;
   assign if_pc_o    = inst_addr;
   assign stallreq_o = (ce_i == ChipEnable && state != IfDone) ? Stop : NoStop;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scenario bench for inst_fetch with a hand-driven bus.
// Revision 1.0
`default_nettype none

module tb_inst_fetch;

   logic        clk;
   logic        rst;
   logic [31:0] pc_i;
   logic        ce_i;
   logic        flush_i;
   logic [5:0]  stall_i;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic [31:0] inst_rdata;
   logic        inst_data_ok;
   logic        stallreq_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic        if_valid_o;

   int errors = 0;
   int checks = 0;

   inst_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .pc_i         (pc_i),
      .ce_i         (ce_i),
      .flush_i      (flush_i),
      .stall_i      (stall_i),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_rdata   (inst_rdata),
      .inst_data_ok (inst_data_ok),
      .stallreq_o   (stallreq_o),
      .if_pc_o      (if_pc_o),
      .if_inst_o    (if_inst_o),
      .if_valid_o   (if_valid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      flush_i      = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ce_i = 1'b0; pc_i = 32'h0; stall_i = 6'b0; inst_rdata = 32'h0;
      bus_idle();
      @(negedge clk);
      checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", inst_req); end
      checks++; if (inst_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 00000000", inst_addr); end
      checks++; if (if_valid_o !== 1'b0 || if_inst_o !== 32'h0 || if_pc_o !== 32'h0) begin
         errors++; $display("FAIL reset_if: got v=%b inst=%h pc=%h exp 0/0/0", if_valid_o, if_inst_o, if_pc_o);
      end
      next();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stallreq: got %b exp 0", stallreq_o); end
      next();
   endtask

   task automatic test_zero_wait();
      // IDLE, issuing
      ce_i = 1'b1; pc_i = 32'hBFC00000;
      @(negedge clk);
      checks++; if (inst_req !== 1'b0 || stallreq_o !== 1'b1) begin
         errors++; $display("FAIL zw_idle: got req=%b stallreq=%b exp 0/1", inst_req, stallreq_o);
      end
      next();
      // REQ, accepted immediately
      inst_addr_ok = 1'b1;
      @(negedge clk);
      checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00000) begin
         errors++; $display("FAIL zw_req: got req=%b addr=%h exp 1/bfc00000", inst_req, inst_addr);
      end
      next();
      // WAIT, data returns
      inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3C080001;
      @(negedge clk);
      checks++; if (inst_req !== 1'b0 || if_valid_o !== 1'b0 || stallreq_o !== 1'b1) begin
         errors++; $display("FAIL zw_wait: got req=%b v=%b stallreq=%b exp 0/0/1", inst_req, if_valid_o, stallreq_o);
      end
      next();
      // DONE
      inst_data_ok = 1'b0; ce_i = 1'b0;
      @(negedge clk);
      checks++; if (if_valid_o !== 1'b1 || if_inst_o !== 32'h3C080001 || if_pc_o !== 32'hBFC00000) begin
         errors++; $display("FAIL zw_done: got v=%b inst=%h pc=%h exp 1/3c080001/bfc00000", if_valid_o, if_inst_o, if_pc_o);
      end
      ce_i = 1'b1;
      #1;
      checks++; if (stallreq_o !== 1'b0) begin errors++; $display("FAIL zw_done_stallreq: got %b exp 0", stallreq_o); end
      ce_i = 1'b0;
      next();
      @(negedge clk);
      checks++; if (if_valid_o !== 1'b0 || if_inst_o !== 32'h0) begin
         errors++; $display("FAIL zw_after: got v=%b inst=%h exp 0/00000000", if_valid_o, if_inst_o);
      end
      next();
   endtask

   task automatic test_addr_delay();
      ce_i = 1'b1; pc_i = 32'hBFC00004;
      next();
      for (int i = 0; i < 4; i++) begin
         inst_addr_ok = (i == 3);
         @(negedge clk);
         checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00004 || stallreq_o !== 1'b1) begin
            errors++; $display("FAIL ad_hold%0d: got req=%b addr=%h stallreq=%b exp 1/bfc00004/1", i, inst_req, inst_addr, stallreq_o);
         end
         next();
      end
      inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h24020005;
      next();
      inst_data_ok = 1'b0; ce_i = 1'b0;
      @(negedge clk);
      checks++; if (if_valid_o !== 1'b1 || if_inst_o !== 32'h24020005 || if_pc_o !== 32'hBFC00004) begin
         errors++; $display("FAIL ad_done: got v=%b inst=%h pc=%h exp 1/24020005/bfc00004", if_valid_o, if_inst_o, if_pc_o);
      end
      next();
      next();
   endtask

   task automatic test_flush_wait();
      // A flush in IDLE must not issue
      ce_i = 1'b1; pc_i = 32'hBFC00100; flush_i = 1'b1;
      next();
      flush_i = 1'b0;
      @(negedge clk);
      checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL fw_idle_flush: got req=%b exp 0", inst_req); end
      next();
      inst_addr_ok = 1'b1;
      next();
      // WAIT: redirect without data
      inst_addr_ok = 1'b0; flush_i = 1'b1; pc_i = 32'hBFC00380;
      next();
      // DISCARD: data arrives and is dropped
      flush_i = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hDEADBEEF;
      @(negedge clk);
      checks++; if (if_valid_o !== 1'b0 || stallreq_o !== 1'b1) begin
         errors++; $display("FAIL fw_discard: got v=%b stallreq=%b exp 0/1", if_valid_o, stallreq_o);
      end
      next();
      inst_data_ok = 1'b0;
      @(negedge clk);
      checks++; if (if_valid_o !== 1'b0 || if_inst_o !== 32'h0) begin
         errors++; $display("FAIL fw_dropped: got v=%b inst=%h exp 0/00000000", if_valid_o, if_inst_o);
      end
      next();
      inst_addr_ok = 1'b1;
      @(negedge clk);
      checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00380) begin
         errors++; $display("FAIL fw_newpc: got req=%b addr=%h exp 1/bfc00380", inst_req, inst_addr);
      end
      next();
      inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h8C010010;
      next();
      inst_data_ok = 1'b0; ce_i = 1'b0;
      @(negedge clk);
      checks++; if (if_valid_o !== 1'b1 || if_inst_o !== 32'h8C010010 || if_pc_o !== 32'hBFC00380) begin
         errors++; $display("FAIL fw_done: got v=%b inst=%h pc=%h exp 1/8c010010/bfc00380", if_valid_o, if_inst_o, if_pc_o);
      end
      next();
      next();
   endtask

   task automatic test_flush_req();
      ce_i = 1'b1; pc_i = 32'hBFC00200;
      next();
      // REQ: flush before acceptance
      flush_i = 1'b1;
      next();
      flush_i = 1'b0; pc_i = 32'hBFC00400; inst_addr_ok = 1'b1;
      @(negedge clk);
      checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00200) begin
         errors++; $display("FAIL fr_held: got req=%b addr=%h exp 1/bfc00200", inst_req, inst_addr);
      end
      next();
      inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h11111111; ce_i = 1'b0;
      next();
      inst_data_ok = 1'b0;
      @(negedge clk);
      checks++; if (if_valid_o !== 1'b0 || if_inst_o !== 32'h0 || inst_req !== 1'b0) begin
         errors++; $display("FAIL fr_dropped: got v=%b inst=%h req=%b exp 0/00000000/0", if_valid_o, if_inst_o, inst_req);
      end
      next();
   endtask

   task automatic test_done_stall();
      ce_i = 1'b1; pc_i = 32'hBFC00010;
      next();
      inst_addr_ok = 1'b1;
      next();
      inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hAABBCCDD;
      next();
      inst_data_ok = 1'b0; stall_i = 6'b000010;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++; if (if_valid_o !== 1'b1 || if_inst_o !== 32'hAABBCCDD || if_pc_o !== 32'hBFC00010 || inst_req !== 1'b0) begin
            errors++; $display("FAIL ds_hold%0d: got v=%b inst=%h pc=%h req=%b exp 1/aabbccdd/bfc00010/0", i, if_valid_o, if_inst_o, if_pc_o, inst_req);
         end
         next();
      end
      stall_i = 6'b0;
      next();
      pc_i = 32'hBFC00014;
      @(negedge clk);
      checks++; if (if_valid_o !== 1'b0 || inst_req !== 1'b0) begin
         errors++; $display("FAIL ds_idle: got v=%b req=%b exp 0/0", if_valid_o, inst_req);
      end
      next();
      @(negedge clk);
      checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00014) begin
         errors++; $display("FAIL ds_next: got req=%b addr=%h exp 1/bfc00014", inst_req, inst_addr);
      end
   endtask

   task automatic test_reset_mid();
      // Continues from REQ of the previous scenario
      next();
      inst_addr_ok = 1'b1;
      next();
      inst_addr_ok = 1'b0;
      // In WAIT: asynchronous reset between edges
      #2;
      rst = 1'b1;
      #1;
      checks++; if (inst_req !== 1'b0 || inst_addr !== 32'h0 || if_pc_o !== 32'h0 || if_valid_o !== 1'b0) begin
         errors++; $display("FAIL rm_async: got req=%b addr=%h pc=%h v=%b exp 0/0/0/0", inst_req, inst_addr, if_pc_o, if_valid_o);
      end
      ce_i = 1'b0;
      next();
      rst = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h55555555;
      next();
      inst_data_ok = 1'b0;
      @(negedge clk);
      checks++; if (if_valid_o !== 1'b0 || if_inst_o !== 32'h0 || inst_req !== 1'b0) begin
         errors++; $display("FAIL rm_ignored: got v=%b inst=%h req=%b exp 0/00000000/0", if_valid_o, if_inst_o, inst_req);
      end
      next();
      ce_i = 1'b1; pc_i = 32'hBFC00020;
      next();
      @(negedge clk);
      checks++; if (inst_req !== 1'b1 || inst_addr !== 32'hBFC00020) begin
         errors++; $display("FAIL rm_reissue: got req=%b addr=%h exp 1/bfc00020", inst_req, inst_addr);
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_addr_delay();
      test_flush_wait();
      test_flush_req();
      test_done_stall();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch bus stage directly downstream of the program counter.
- Consumes pc/ce and issues one instruction read at a time on an SRAM-like handshake bus (req/addr_ok/data_ok).
- Holds the program counter and upstream stages via a stall request while a fetch is in flight.
- Presents {pc, inst, valid} to the IF/ID register; drops in-flight results on a redirect (branch or exception).

Parameters:
- RESET_ADDR, 32'h00000000: reset value of inst_addr and if_pc_o.
- NOP_INST, 32'h00000000: value driven on if_inst_o when no valid instruction is presented.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- pc_i  in  32  fetch address from the PC stage.
- ce_i  in  1  PC chip enable; 0 means do not fetch.
- flush_i  in  1  redirect this cycle (cp0 branch or branch taken); the PC takes a new value at the next edge.
- stall_i  in  6  pipeline stall vector; bit1=1 means IF/ID holds.
- inst_req  out  1  bus request, registered.
- inst_addr  out  32  bus address, registered, stable while inst_req=1.
- inst_addr_ok  in  1  address accepted.
- inst_rdata  in  32  read data, valid with inst_data_ok.
- inst_data_ok  in  1  read data return.
- stallreq_o  out  1  stall request to the stall controller.
- if_pc_o  out  32  pc of the presented instruction.
- if_inst_o  out  32  presented instruction.
- if_valid_o  out  1  if_pc_o/if_inst_o are valid.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, inst_req=0, inst_addr=RESET_ADDR.
  - Instruction buffer=NOP_INST, if_pc_o=RESET_ADDR, if_valid_o=0.
- States: IDLE, REQ, WAIT, DISCARD, DONE. One outstanding request maximum.
- IDLE:
  - If ce_i=1 and flush_i=0: inst_req<=1, inst_addr<=pc_i, go REQ.
  - Otherwise stay in IDLE; never issue on a flush cycle, because pc_i is stale.
- REQ:
  - Hold inst_req=1 and inst_addr unchanged until inst_addr_ok=1. A request is never retracted.
  - On addr_ok: inst_req<=0. Go DISCARD if flush_i was seen in REQ (sticky drop flag) or flush_i=1 this cycle; else go WAIT.
- WAIT:
  - data_ok with flush_i=1: drop the data, go IDLE.
  - data_ok with flush_i=0: buffer inst_rdata, go DONE.
  - flush_i without data_ok: go DISCARD.
- DISCARD:
  - On data_ok: drop the data, go IDLE. flush_i is ignored in this state.
- DONE:
  - if_valid_o=1, if_inst_o=buffer, if_pc_o=inst_addr.
  - flush_i=1: go IDLE, drop the buffer.
  - else stall_i[1]=0: IF/ID captures at this edge; go IDLE.
  - else stall_i[1]=1: stay in DONE, buffer held.
- Bus rule: inst_data_ok is never expected in the same cycle as inst_addr_ok; a data_ok outside WAIT/DISCARD is ignored.
- Outputs:
  - if_valid_o=1 only in DONE; outside DONE if_inst_o=NOP_INST and if_valid_o=0.
  - stallreq_o = ce_i & (state != DONE), combinational.
- Timing: a zero-wait bus (addr_ok in REQ's first cycle, data_ok the next) gives 3 cycles from IDLE to DONE and a 4-cycle instruction period.
- Reset mid-transaction: everything returns to IDLE and the outstanding response is ignored; the bus must tolerate a dropped request.

Decomposition:
- Shared defines file: state encodings (IfIdle, IfReq, IfWait, IfDiscard, IfDone), plus the existing Stop/NoStop, ChipEnable and ZeroWord constants.
- No sub-module: a single FSM plus one 32-bit buffer and one drop flag.

Test Plan:
- Reset then ce_i=1, pc_i=BFC00000, bus zero-wait returning 3C080001 → inst_req high 1 cycle with inst_addr=BFC00000; DONE 3 cycles after issue; if_inst_o=3C080001, if_valid_o=1, stallreq_o=0 only in DONE.
- addr_ok delayed 3 cycles → inst_req and inst_addr held stable for 4 cycles; stallreq_o=1 throughout.
- flush_i pulsed in WAIT, data_ok returns DEADBEEF → data dropped, if_valid_o stays 0; next request uses the new pc_i=BFC00380.
- flush_i in REQ before addr_ok → request completes, goes to DISCARD, and the response is dropped.
- DONE with stall_i[1]=1 for 5 cycles → if_inst_o/if_pc_o constant, no new inst_req; on release goes to IDLE, then issues pc+4.
- rst asserted while in WAIT → outputs reset immediately (asynchronous); a later data_ok is ignored and state is IDLE.
